carry_select_adder: RTL and testbench



---
 rtl/carry_select_adder_if.sv | 23 ++
 rtl/carry_select_adder.sv | 104 ++++++++++
 tb/tb_carry_select_adder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/carry_select_adder_if.sv
// Operand/result bundle for the registered carry-select adder.
// The master drives the operands and the slave returns the registered result.
interface carry_select_adder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;

  modport master (
    output a, b, cin, in_valid,
    input  sum, cout, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output sum, cout, out_valid
  );
endinterface

// File: rtl/carry_select_adder.sv
// Registered unsigned adder {cout, sum} = a + b + cin, built as a ripple base block
// followed by carry-select blocks; the result is registered with a valid flag.
module carry_select_adder #(
  parameter int WIDTH = 4,
  parameter int BLOCK = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  carry_select_adder_if.slave  bus
);

  localparam int NBLK = (WIDTH + BLOCK - 1) / BLOCK;

  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             out_valid_r;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LO = k * BLOCK;
    localparam int W  = ((WIDTH - LO) < BLOCK) ? (WIDTH - LO) : BLOCK;

    logic [W-1:0] x_s;
    logic [W-1:0] y_s;
    logic [W-1:0] bs_s;
    logic         co_s;

    assign x_s = bus.a[LO +: W];
    assign y_s = bus.b[LO +: W];

    if (k == 0) begin : g_ripple
      // Base block: plain ripple chain fed by the external carry-in
      always_comb begin : p_ripple
        logic c;
        c    = bus.cin;
        bs_s = '0;
        for (int i = 0; i < W; i++) begin
          bs_s[i] = x_s[i] ^ y_s[i] ^ c;
          c       = (x_s[i] & y_s[i]) | (c & (x_s[i] ^ y_s[i]));
        end
        co_s = c;
      end
    end else begin : g_select
      logic [W-1:0] s0_s;
      logic [W-1:0] s1_s;
      logic         c0_s;
      logic         c1_s;

      // Speculative chains for carry-in 0 and carry-in 1
      always_comb begin : p_dual
        logic k0;
        logic k1;
        k0   = 1'b0;
        k1   = 1'b1;
        s0_s = '0;
        s1_s = '0;
        for (int i = 0; i < W; i++) begin
          s0_s[i] = x_s[i] ^ y_s[i] ^ k0;
          k0      = (x_s[i] & y_s[i]) | (k0 & (x_s[i] ^ y_s[i]));
          s1_s[i] = x_s[i] ^ y_s[i] ^ k1;
          k1      = (x_s[i] & y_s[i]) | (k1 & (x_s[i] ^ y_s[i]));
        end
        c0_s = k0;
        c1_s = k1;
      end

      // Pick the speculative result using the resolved carry of the block below
      always_comb begin : p_mux
        if (g_blk[k-1].co_s) begin
          bs_s = s1_s;
          co_s = c1_s;
        end else begin
          bs_s = s0_s;
          co_s = c0_s;
        end
      end
    end

    assign sum_s[LO +: W] = bs_s;
  end

  assign cout_s = g_blk[NBLK-1].co_s;

  // Result register: capture on in_valid, otherwise hold the data and drop valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_r       <= '0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (bus.in_valid) begin
      sum_r       <= sum_s;
      cout_r      <= cout_s;
      out_valid_r <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_carry_select_adder.sv
// Scoreboard bench: WIDTH=4 with BLOCK 1..4 swept exhaustively plus a WIDTH=16/BLOCK=4
// instance under random operands, all checked against plain a+b+cin arithmetic.
module tb_carry_select_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        vld;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        cin4;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        cin16;

  typedef struct packed {
    logic [5:0]  r4;
    logic [17:0] r16;
  } exp_t;

  exp_t        exp_q[$];
  logic [5:0]  m4;
  logic [17:0] m16;
  int          n_cmp = 0;
  int          n_bad = 0;

  // {a, b, cin} directed vectors
  logic [8:0] dir_v [0:5] = '{
    {4'b1010, 4'b1100, 1'b0},
    {4'b0110, 4'b0111, 1'b1},
    {4'b1001, 4'b0100, 1'b0},
    {4'b1111, 4'b0010, 1'b1},
    {4'b0111, 4'b0000, 1'b1},
    {4'b1111, 4'b1111, 1'b1}
  };

  carry_select_adder_if #(.WIDTH(4))  if_b1 ();
  carry_select_adder_if #(.WIDTH(4))  if_b2 ();
  carry_select_adder_if #(.WIDTH(4))  if_b3 ();
  carry_select_adder_if #(.WIDTH(4))  if_b4 ();
  carry_select_adder_if #(.WIDTH(16)) if_w16 ();

  assign if_b1.a = a4;  assign if_b1.b = b4;  assign if_b1.cin = cin4;  assign if_b1.in_valid = vld;
  assign if_b2.a = a4;  assign if_b2.b = b4;  assign if_b2.cin = cin4;  assign if_b2.in_valid = vld;
  assign if_b3.a = a4;  assign if_b3.b = b4;  assign if_b3.cin = cin4;  assign if_b3.in_valid = vld;
  assign if_b4.a = a4;  assign if_b4.b = b4;  assign if_b4.cin = cin4;  assign if_b4.in_valid = vld;
  assign if_w16.a = a16; assign if_w16.b = b16; assign if_w16.cin = cin16; assign if_w16.in_valid = vld;

  carry_select_adder #(.WIDTH(4),  .BLOCK(1)) u_b1  (.clk(clk), .rst_n(rst_n), .bus(if_b1.slave));
  carry_select_adder #(.WIDTH(4),  .BLOCK(2)) u_b2  (.clk(clk), .rst_n(rst_n), .bus(if_b2.slave));
  carry_select_adder #(.WIDTH(4),  .BLOCK(3)) u_b3  (.clk(clk), .rst_n(rst_n), .bus(if_b3.slave));
  carry_select_adder #(.WIDTH(4),  .BLOCK(4)) u_b4  (.clk(clk), .rst_n(rst_n), .bus(if_b4.slave));
  carry_select_adder #(.WIDTH(16), .BLOCK(4)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(if_w16.slave));

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got {valid,cout,sum}=%h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: predict the state after the coming edge, queue it, advance one cycle
  task automatic step();
    logic [4:0]  s4;
    logic [16:0] s16;
    s4  = 5'(a4) + 5'(b4) + 5'(cin4);
    s16 = 17'(a16) + 17'(b16) + 17'(cin16);
    if (!rst_n) begin
      m4  = '0;
      m16 = '0;
    end else if (vld) begin
      m4  = {1'b1, s4};
      m16 = {1'b1, s16};
    end else begin
      m4[5]   = 1'b0;
      m16[17] = 1'b0;
    end
    exp_q.push_back('{r4: m4, r16: m16});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c);
    a4    = a;
    b4    = b;
    cin4  = c;
    a16   = 16'($urandom);
    b16   = 16'($urandom);
    cin16 = 1'($urandom_range(0, 1));
    step();
  endtask

  // Monitor: after every edge compare all instances with the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("w4_blk1",  {12'b0, if_b1.out_valid, if_b1.cout, if_b1.sum}, {12'b0, e.r4});
        check("w4_blk2",  {12'b0, if_b2.out_valid, if_b2.cout, if_b2.sum}, {12'b0, e.r4});
        check("w4_blk3",  {12'b0, if_b3.out_valid, if_b3.cout, if_b3.sum}, {12'b0, e.r4});
        check("w4_blk4",  {12'b0, if_b4.out_valid, if_b4.cout, if_b4.sum}, {12'b0, e.r4});
        check("w16_blk4", {if_w16.out_valid, if_w16.cout, if_w16.sum}, e.r16);
      end
    end
  end

  initial begin
    logic [8:0] v;
    rst_n = 1'b0;
    vld   = 1'b1;
    drive4(4'b1111, 4'b1111, 1'b1);
    drive4(4'b1111, 4'b1111, 1'b1);

    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v = dir_v[i];
      drive4(v[8:5], v[4:1], v[0]);
    end

    // Hold: a valid result followed by idle cycles with moving operands
    drive4(4'b1010, 4'b1100, 1'b0);
    vld = 1'b0;
    repeat (3) drive4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));

    // Reset with an operand in flight, then the first operand after release
    vld   = 1'b1;
    rst_n = 1'b0;
    drive4(4'b0101, 4'b0011, 1'b0);
    rst_n = 1'b1;
    drive4(4'b0101, 4'b0011, 1'b0);

    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      drive4(v[8:5], v[4:1], v[0]);
    end

    repeat (600) begin
      vld   = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 31) != 0);
      drive4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    rst_n = 1'b1;
    vld   = 1'b0;
    drive4(4'b0000, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
